// File: rtl/pe_ctx_loader_pkg.sv
// Shared constants and helpers for the PE context loader.
// The constants mirror the PE config-buffer geometry.
package pe_ctx_loader_pkg;

  localparam int INST_W    = 48;
  localparam int DEPTH     = 32;
  localparam int LEN_W     = 6;
  localparam int DRAIN_CYC = 2;
  localparam int DRAIN_W   = 2;

  // A program is legal when it holds 1..DEPTH words and runs 1..ctx_len cycles.
  function automatic logic lengths_legal(input logic [LEN_W-1:0] ctx_len,
                                         input logic [LEN_W-1:0] run_len);
    return (ctx_len != '0) && (ctx_len <= LEN_W'(DEPTH)) &&
           (run_len != '0) && (run_len <= ctx_len);
  endfunction

endpackage

// File: rtl/pe_ctx_loader_if.sv
// Instruction stream from the array-level config fetch into the loader.
interface pe_ctx_loader_if;
  import pe_ctx_loader_pkg::*;

  // A beat transfers on a rising edge where inst_valid and inst_ready are both high.
  // The source holds inst_data stable while inst_valid is high and not yet accepted;
  // inst_ready does not depend combinationally on inst_valid.
  logic [INST_W-1:0] inst_data;
  logic              inst_valid;
  logic              inst_ready;

  modport master (output inst_data, output inst_valid, input inst_ready);
  modport slave  (input inst_data, input inst_valid, output inst_ready);

endinterface

// File: rtl/pe_ctx_loader.sv
// Sequencer that clears a PE, streams a program into its config buffer,
// runs it for run_len cycles and drains the PE pipeline before pulsing done.
module pe_ctx_loader
  import pe_ctx_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    ctx_len,
  input  logic [LEN_W-1:0]    run_len,
  pe_ctx_loader_if.slave      inst,
  output logic                pe_rst,
  output logic [INST_W-1:0]   PE_inst,
  output logic                init,
  output logic                run,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         state;
  logic [LEN_W-1:0]   ctx_q;
  logic [LEN_W-1:0]   run_q;
  logic [LEN_W-1:0]   load_cnt;
  logic [LEN_W-1:0]   run_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ctx_q          <= '0;
      run_q          <= '0;
      load_cnt       <= '0;
      run_cnt        <= '0;
      drain_cnt      <= '0;
      pe_rst         <= 1'b0;
      PE_inst        <= '0;
      init           <= 1'b0;
      run            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      inst.inst_ready <= 1'b0;
    end else begin
      pe_rst <= 1'b0;
      init   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (lengths_legal(ctx_len, run_len)) begin
              ctx_q    <= ctx_len;
              run_q    <= run_len;
              load_cnt <= '0;
              run_cnt  <= '0;
              pe_rst   <= 1'b1;
              busy     <= 1'b1;
              state    <= S_CLR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CLR: begin
          inst.inst_ready <= 1'b1;
          state           <= S_LOAD;
        end
        S_LOAD: begin
          if (inst.inst_valid && inst.inst_ready) begin
            PE_inst  <= inst.inst_data;
            init     <= 1'b1;
            load_cnt <= load_cnt + LEN_W'(1);
            // Drop ready right behind the last beat so no extra word is taken.
            if (load_cnt + LEN_W'(1) == ctx_q) begin
              inst.inst_ready <= 1'b0;
              state           <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // run lags the state by one cycle, so the first pulse follows the last init.
          run     <= 1'b1;
          run_cnt <= run_cnt + LEN_W'(1);
          if (run_cnt + LEN_W'(1) == run_q) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          run <= 1'b0;
          if (drain_cnt == DRAIN_W'(DRAIN_CYC)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: begin
          run             <= 1'b0;
          busy            <= 1'b0;
          inst.inst_ready <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule
